// File: rtl/clock_24.sv
// Time-of-day counter (hours:minutes:seconds) advanced by a prescaled one-second tick.
// Optional build macro CLOCK24_DAY_PULSE_EN adds a one-cycle day_pulse at each midnight wrap.
module clock_24 #(
    parameter int CLK_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       propagate,
    input  logic [4:0] in_hours,
    input  logic [5:0] in_minutes,
    output logic [4:0] hours,
    output logic [5:0] minutes,
`ifdef CLOCK24_DAY_PULSE_EN
    output logic       day_pulse,
`endif
    output logic [5:0] seconds
);

    // A one-cycle-per-second build still needs a 1-bit prescaler to keep the code uniform.
    localparam int            PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;

    logic tick;
    logic sec_wrap;
    logic min_wrap;
    logic hr_wrap;

    assign tick     = (presc_q == PRESC_MAX);
    assign sec_wrap = tick && (seconds_q == 6'd59);
    assign min_wrap = sec_wrap && (minutes_q == 6'd59);
    assign hr_wrap  = min_wrap && (hours_q == 5'd23);

    // A load wins over a coincident tick; out-of-range load fields collapse to zero.
    always_comb begin
        presc_d   = presc_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (propagate) begin
            presc_d   = '0;
            seconds_d = 6'd0;
            hours_d   = (in_hours > 5'd23) ? 5'd0 : in_hours;
            minutes_d = (in_minutes > 6'd59) ? 6'd0 : in_minutes;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                seconds_d = sec_wrap ? 6'd0 : seconds_q + 6'd1;
            end
            if (sec_wrap) begin
                minutes_d = min_wrap ? 6'd0 : minutes_q + 6'd1;
            end
            if (min_wrap) begin
                hours_d = hr_wrap ? 5'd0 : hours_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            hours_q   <= 5'd0;
            minutes_q <= 6'd0;
            seconds_q <= 6'd0;
        end else begin
            presc_q   <= presc_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
        end
    end

    assign hours   = hours_q;
    assign minutes = minutes_q;
    assign seconds = seconds_q;

`ifdef CLOCK24_DAY_PULSE_EN
    logic day_pulse_q, day_pulse_d;

    assign day_pulse_d = !propagate && hr_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            day_pulse_q <= 1'b0;
        end else begin
            day_pulse_q <= day_pulse_d;
        end
    end

    assign day_pulse = day_pulse_q;
`endif

endmodule

// File: tb/tb_clock_24.sv
// Self-checking bench for clock_24: one instance at 1 clock/second, one at 4 clocks/second.
module tb_clock_24;

  logic       clk;
  logic       reset;
  logic       propagate;
  logic [4:0] in_hours;
  logic [5:0] in_minutes;

  logic [4:0] h1, h4;
  logic [5:0] m1, m4;
  logic [5:0] s1, s4;
`ifdef CLOCK24_DAY_PULSE_EN
  logic       dp1, dp4;
  int         dp1_count;
`endif

  int tests_run;
  int tests_failed;

  clock_24 #(.CLK_PER_SEC(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .propagate  (propagate),
    .in_hours   (in_hours),
    .in_minutes (in_minutes),
    .hours      (h1),
    .minutes    (m1),
`ifdef CLOCK24_DAY_PULSE_EN
    .day_pulse  (dp1),
`endif
    .seconds    (s1)
  );

  clock_24 #(.CLK_PER_SEC(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .propagate  (propagate),
    .in_hours   (in_hours),
    .in_minutes (in_minutes),
    .hours      (h4),
    .minutes    (m4),
`ifdef CLOCK24_DAY_PULSE_EN
    .day_pulse  (dp4),
`endif
    .seconds    (s4)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, time limit exceeded");
    $fatal(1, "watchdog");
  end

`ifdef CLOCK24_DAY_PULSE_EN
  always @(negedge clk) if (dp1 === 1'b1) dp1_count++;
`endif

  typedef struct {
    bit         prop;
    logic [4:0] in_h;
    logic [5:0] in_m;
    int         wait_edges;
    logic [4:0] exp_h;
    logic [5:0] exp_m;
    logic [5:0] exp_s;
  } vec_t;

  vec_t vecs[12];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_hms(input string name, input logic [4:0] ah, input logic [5:0] am,
                           input logic [5:0] as_, input logic [4:0] eh, input logic [5:0] em,
                           input logic [5:0] es);
    tests_run++;
    if (ah !== eh || am !== em || as_ !== es) begin
      tests_failed++;
      $display("FAIL %s: got %0d:%0d:%0d expected %0d:%0d:%0d", name, ah, am, as_, eh, em, es);
    end
  endtask

  task automatic load(input logic [4:0] hh, input logic [5:0] mm);
    propagate  = 1'b1;
    in_hours   = hh;
    in_minutes = mm;
    step(1);
    propagate  = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef CLOCK24_DAY_PULSE_EN
    dp1_count = 0;
`endif
    reset      = 1'b1;
    propagate  = 1'b0;
    in_hours   = 5'd0;
    in_minutes = 6'd0;
    #1;
    check_hms("reset_state_1", h1, m1, s1, 5'd0, 6'd0, 6'd0);
    check_hms("reset_state_4", h4, m4, s4, 5'd0, 6'd0, 6'd0);

    // propagate ignored while reset is high
    propagate = 1'b1; in_hours = 5'd8; in_minutes = 6'd8;
    step(2);
    check_hms("load_in_reset", h1, m1, s1, 5'd0, 6'd0, 6'd0);
    propagate = 1'b0;
    reset = 1'b0;

    vecs[0]  = '{1'b1, 5'd4,  6'd30, 0,  5'd4,  6'd30, 6'd0};
    vecs[1]  = '{1'b0, 5'd0,  6'd0,  1,  5'd4,  6'd30, 6'd1};
    vecs[2]  = '{1'b0, 5'd0,  6'd0,  1,  5'd4,  6'd30, 6'd2};
    vecs[3]  = '{1'b1, 5'd9,  6'd59, 59, 5'd9,  6'd59, 6'd59};
    vecs[4]  = '{1'b0, 5'd0,  6'd0,  1,  5'd10, 6'd0,  6'd0};
    vecs[5]  = '{1'b1, 5'd23, 6'd59, 59, 5'd23, 6'd59, 6'd59};
    vecs[6]  = '{1'b0, 5'd0,  6'd0,  1,  5'd0,  6'd0,  6'd0};
    vecs[7]  = '{1'b1, 5'd25, 6'd61, 0,  5'd0,  6'd0,  6'd0};
    vecs[8]  = '{1'b1, 5'd7,  6'd60, 0,  5'd7,  6'd0,  6'd0};
    vecs[9]  = '{1'b1, 5'd23, 6'd0,  0,  5'd23, 6'd0,  6'd0};
    vecs[10] = '{1'b1, 5'd24, 6'd59, 0,  5'd0,  6'd59, 6'd0};
    vecs[11] = '{1'b1, 5'd0,  6'd59, 61, 5'd1,  6'd0,  6'd1};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].prop) load(vecs[i].in_h, vecs[i].in_m);
      if (vecs[i].wait_edges > 0) step(vecs[i].wait_edges);
      check_hms($sformatf("vec%0d", i), h1, m1, s1, vecs[i].exp_h, vecs[i].exp_m, vecs[i].exp_s);
`ifdef CLOCK24_DAY_PULSE_EN
      if (i == 6) begin
        tests_run++;
        if (dp1_count != 0) begin
          tests_failed++;
          $display("FAIL day_pulse_early: got count %0d expected 0", dp1_count);
        end
        step(2);
        tests_run++;
        if (dp1_count != 1) begin
          tests_failed++;
          $display("FAIL day_pulse_once: got count %0d expected 1", dp1_count);
        end
      end
`endif
    end

    // priority: load lands on the tick edge of the 4-clock instance
    load(5'd2, 6'd3);
    step(3);
    check_hms("presc_pre_tick", h4, m4, s4, 5'd2, 6'd3, 6'd0);
    load(5'd5, 6'd6);
    check_hms("prio_load", h4, m4, s4, 5'd5, 6'd6, 6'd0);
    step(3);
    check_hms("prio_discard", h4, m4, s4, 5'd5, 6'd6, 6'd0);
    step(1);
    check_hms("prio_next_tick", h4, m4, s4, 5'd5, 6'd6, 6'd1);

    // propagate held for three cycles
    propagate = 1'b1; in_hours = 5'd1; in_minutes = 6'd2;
    step(3);
    check_hms("held_load_1", h1, m1, s1, 5'd1, 6'd2, 6'd0);
    propagate = 1'b0;
    step(1);
    check_hms("held_release_1", h1, m1, s1, 5'd1, 6'd2, 6'd1);
    step(2);
    check_hms("held_release_4a", h4, m4, s4, 5'd1, 6'd2, 6'd0);
    step(1);
    check_hms("held_release_4b", h4, m4, s4, 5'd1, 6'd2, 6'd1);

    // reset mid-count at 12:34:56 with no clock edge
    load(5'd12, 6'd34);
    step(56);
    check_hms("pre_reset", h1, m1, s1, 5'd12, 6'd34, 6'd56);
    #2;
    reset = 1'b1;
    #1;
    check_hms("async_reset_1", h1, m1, s1, 5'd0, 6'd0, 6'd0);
    check_hms("async_reset_4", h4, m4, s4, 5'd0, 6'd0, 6'd0);
    step(1);
    reset = 1'b0;
    step(1);
    check_hms("post_reset_1", h1, m1, s1, 5'd0, 6'd0, 6'd1);
    step(2);
    check_hms("post_reset_4a", h4, m4, s4, 5'd0, 6'd0, 6'd0);
    step(1);
    check_hms("post_reset_4b", h4, m4, s4, 5'd0, 6'd0, 6'd1);

    // reset during a pending load: nothing of the load survives
    propagate = 1'b1; in_hours = 5'd15; in_minutes = 6'd45;
    reset = 1'b1;
    step(1);
    check_hms("reset_mid_load", h1, m1, s1, 5'd0, 6'd0, 6'd0);
    propagate = 1'b0;
    reset = 1'b0;
    step(1);
    check_hms("reset_mid_load_rel", h1, m1, s1, 5'd0, 6'd0, 6'd1);

`ifdef CLOCK24_DAY_PULSE_EN
    tests_run++;
    if (dp1_count != 1) begin
      tests_failed++;
      $display("FAIL day_pulse_total: got count %0d expected 1", dp1_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clock_24.md
CLOCK_24 -- requirements
Module: clock_24

Interface
REQ-001 SHALL have parameter: CLK_PER_SEC, default 1, clock cycles per one-second tick; legal range 1..2^26.
REQ-002 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: propagate  input  1  synchronous load strobe for time-of-day.
REQ-005 SHALL have port: in_hours  input  5  hours value to load, 0..23.
REQ-006 SHALL have port: in_minutes  input  6  minutes value to load, 0..59.
REQ-007 SHALL have port: hours  output  5  current hours, 0..23, registered.
REQ-008 SHALL have port: minutes  output  6  current minutes, 0..59, registered.
REQ-009 SHALL have port: seconds  output  6  current seconds, 0..59, registered.

Function
REQ-010 SHALL hold an internal prescaler counting 0..CLK_PER_SEC-1, wide enough for that range; a tick occurs on the edge where the prescaler is at CLK_PER_SEC-1, and the prescaler then wraps to 0.
REQ-011 SHALL, with CLK_PER_SEC=1, tick on every clock edge.
REQ-012 SHALL, on a tick, increment seconds; at 59 the tick sets seconds to 0 and carries into minutes.
REQ-013 SHALL, on a minutes carry, increment minutes; at 59 the carry sets minutes to 0 and carries into hours.
REQ-014 SHALL, on an hours carry, increment hours; at 23 the carry sets hours to 0, giving a full wrap 23:59:59 -> 00:00:00 in one tick.
REQ-015 SHALL, with propagate=1 at a rising edge, load hours<=in_hours and minutes<=in_minutes, and set seconds and the prescaler to 0; the loaded values are visible right after that edge.
REQ-016 SHALL give propagate priority over a simultaneous tick; that tick is discarded.
REQ-017 SHALL, when in_hours>23, load hours as 0; when in_minutes>59, SHALL load minutes as 0; each field is checked independently.
REQ-018 SHALL, with propagate held high for N cycles, reload on every one of those cycles; counting resumes on the first edge with propagate=0, and the first tick comes CLK_PER_SEC edges after the last load.
REQ-019 SHALL never present an out-of-range value on hours, minutes or seconds.

Reset
REQ-020 SHALL, while reset=1, force hours=0, minutes=0, seconds=0 and prescaler=0 immediately, without waiting for a clock edge.
REQ-021 SHALL ignore propagate and ticks while reset=1; the first tick after release comes CLK_PER_SEC edges after release.
REQ-022 SHALL, when reset is asserted mid-count or mid-load, abandon that operation with no partial update.

Configuration
REQ-023 SHALL, with macro CLOCK24_DAY_PULSE_EN defined, add output day_pulse (1 bit, registered, reset 0).
- day_pulse is high for exactly one cycle, the cycle after the edge on which the time wraps 23:59:59 -> 00:00:00.
- day_pulse is not asserted by propagate or by reset.
REQ-024 SHALL, without CLOCK24_DAY_PULSE_EN, have no day_pulse port and no associated logic; all other behaviour is identical.

Verification
REQ-025 SHALL cover reset: assert reset mid-count at 12:34:56 with no clock edge -> outputs 00:00:00 at once; release -> 00:00:01 after CLK_PER_SEC edges.
REQ-026 SHALL cover load: CLK_PER_SEC=1, propagate pulsed for one cycle with in_hours=4, in_minutes=30 -> 04:30:00 after that edge, then 04:30:01 and 04:30:02 on the next two edges.
REQ-027 SHALL cover carries: load 09:59:00, CLK_PER_SEC=1 -> 09:59:59 after 59 edges, 10:00:00 on the next edge.
REQ-028 SHALL cover day wrap: load 23:59:00 -> 00:00:00 after 60 edges; with CLOCK24_DAY_PULSE_EN, day_pulse is high for exactly one cycle.
REQ-029 SHALL cover prescaler and priority: CLK_PER_SEC=4, propagate asserted on a tick edge -> tick discarded, seconds=00, next increment 4 edges later.
REQ-030 SHALL cover invalid load: in_hours=25, in_minutes=61 -> 00:00:00; in_hours=7, in_minutes=60 -> 07:00:00.
